// File: rtl/bclk_training_ctrl.sv
// BCLK training sequencer: sweeps the training IOD delay line tap by tap and reports the edge tap.
// Optional eye-monitor qualification is enabled by defining BCLK_TRN_EYE_MON_EN.
module bclk_training_ctrl #(
  parameter int unsigned MAX_TAPS      = 128,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned SAMPLES       = 16
) (
  input  logic       FAB_CLK,
  input  logic       RESET_N,
  input  logic       START,
  input  logic [7:0] RX_DATA,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  input  logic       EYE_MONITOR_EARLY,
  input  logic       EYE_MONITOR_LATE,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic       EYE_MONITOR_CLEAR_FLAGS,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [7:0] EDGE_TAP,
  output logic [7:0] REF_PATTERN
);

  localparam int unsigned CW          = 8;
  localparam logic [7:0]  LAST_TAP    = 8'(MAX_TAPS - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL, S_STEP, S_DONE, S_FAIL
  } state_t;

  state_t          state;
  logic [7:0]      tap;
  logic [CW-1:0]   cnt;
  logic [7:0]      cur;
  logic            unstable;
  logic            eye_hit;

`ifdef BCLK_TRN_EYE_MON_EN
  localparam logic EYE_EN = 1'b1;
  assign eye_hit = EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
`else
  localparam logic EYE_EN = 1'b0;
  logic unused_eye_flags;
  assign eye_hit          = 1'b0;
  assign unused_eye_flags = EYE_MONITOR_EARLY ^ EYE_MONITOR_LATE;
`endif

  // Delay line is only ever swept upward.
  assign DELAY_LINE_DIRECTION = 1'b1;

  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      state                   <= S_IDLE;
      DELAY_LINE_LOAD         <= 1'b0;
      DELAY_LINE_MOVE         <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
      BUSY                    <= 1'b0;
      DONE                    <= 1'b0;
      ERR                     <= 1'b0;
      EDGE_TAP                <= 8'd0;
      REF_PATTERN             <= 8'd0;
      tap                     <= 8'd0;
      cnt                     <= '0;
      cur                     <= 8'd0;
      unstable                <= 1'b0;
    end else begin
      DELAY_LINE_LOAD         <= 1'b0;
      DELAY_LINE_MOVE         <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (START) begin
            state           <= S_LOAD;
            DELAY_LINE_LOAD <= 1'b1;
            BUSY            <= 1'b1;
            DONE            <= 1'b0;
            ERR             <= 1'b0;
          end
        end
        S_LOAD: begin
          tap                     <= 8'd0;
          cnt                     <= '0;
          EYE_MONITOR_CLEAR_FLAGS <= EYE_EN;
          state                   <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_SAMPLE: begin
          // First word becomes the tap's candidate; later words only flag instability.
          if (cnt == '0) begin
            cur      <= RX_DATA;
            unstable <= eye_hit;
          end else if ((RX_DATA != cur) || eye_hit) begin
            unstable <= 1'b1;
          end
          if (cnt == SAMPLE_LAST) begin
            cnt   <= '0;
            state <= S_EVAL;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_EVAL: begin
          if (DELAY_LINE_OUT_OF_RANGE || ((tap == 8'd0) && unstable) ||
              ((tap != 8'd0) && !unstable && (cur == REF_PATTERN) && (tap == LAST_TAP))) begin
            state    <= S_FAIL;
            ERR      <= 1'b1;
            BUSY     <= 1'b0;
            EDGE_TAP <= 8'd0;
          end else if ((tap != 8'd0) && (unstable || (cur != REF_PATTERN))) begin
            state    <= S_DONE;
            DONE     <= 1'b1;
            BUSY     <= 1'b0;
            EDGE_TAP <= tap;
          end else begin
            if (tap == 8'd0) begin
              REF_PATTERN <= cur;
            end
            state           <= S_STEP;
            DELAY_LINE_MOVE <= 1'b1;
          end
        end
        S_STEP: begin
          tap                     <= tap + 8'd1;
          cnt                     <= '0;
          EYE_MONITOR_CLEAR_FLAGS <= EYE_EN;
          state                   <= S_SETTLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bclk_training_ctrl.sv
// Bench for bclk_training_ctrl: behavioural IOD model, scenario table, random scenarios and reset corner.
module tb_bclk_training_ctrl;

  localparam int unsigned MAX_TAPS = 128;
  localparam int unsigned SETTLE   = 8;
  localparam int unsigned SAMPLES  = 16;
  localparam int          NEVER    = 9999;

`ifdef BCLK_TRN_EYE_MON_EN
  localparam bit EYE_ON = 1'b1;
`else
  localparam bit EYE_ON = 1'b0;
`endif

  logic       FAB_CLK, RESET_N, START;
  logic [7:0] RX_DATA;
  logic       DELAY_LINE_OUT_OF_RANGE, EYE_MONITOR_EARLY, EYE_MONITOR_LATE;
  logic       DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS;
  logic       BUSY, DONE, ERR;
  logic [7:0] EDGE_TAP, REF_PATTERN;

  bclk_training_ctrl #(
    .MAX_TAPS(MAX_TAPS), .SETTLE_CYCLES(SETTLE), .SAMPLES(SAMPLES)
  ) dut (
    .FAB_CLK(FAB_CLK), .RESET_N(RESET_N), .START(START), .RX_DATA(RX_DATA),
    .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
    .EYE_MONITOR_EARLY(EYE_MONITOR_EARLY), .EYE_MONITOR_LATE(EYE_MONITOR_LATE),
    .DELAY_LINE_LOAD(DELAY_LINE_LOAD), .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
    .EYE_MONITOR_CLEAR_FLAGS(EYE_MONITOR_CLEAR_FLAGS),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .EDGE_TAP(EDGE_TAP), .REF_PATTERN(REF_PATTERN)
  );

  initial FAB_CLK = 1'b0;
  always #5 FAB_CLK = ~FAB_CLK;

  typedef struct {
    logic [7:0] ref_w;
    logic [7:0] alt_w;
    int         edge_t;
    int         jit_t;
    int         oor_t;
    int         eye_t;
    bit         e_done;
    bit         e_err;
    logic [7:0] e_edge;
    logic [7:0] e_ref;
    int         e_moves;
  } vec_t;

  vec_t vecs[10];

  int n_pass, n_total;
  // Scenario currently applied by the IOD model
  logic [7:0] s_ref, s_alt;
  int s_edge, s_jit, s_oor, s_eye;
  // IOD model state and pulse monitors
  int tap_m, cyc, nload, nmove, nclear, both_hi, dir_bad;
  logic [7:0] ref_model;
  bit timed_out;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive_inputs();
    logic [7:0] w;
    w = (tap_m >= s_edge) ? s_alt : s_ref;
    if (tap_m == s_jit) w = w ^ 8'(cyc & 1);
    RX_DATA                 = w;
    DELAY_LINE_OUT_OF_RANGE = (tap_m >= s_oor);
    EYE_MONITOR_EARLY       = (tap_m == s_eye) && (cyc == int'(SETTLE) + 4);
    EYE_MONITOR_LATE        = 1'b0;
  endtask

  // Called just after a falling edge: observe pulses, advance the IOD model, drive inputs.
  task automatic step_cycle();
    if (DELAY_LINE_LOAD && DELAY_LINE_MOVE) both_hi++;
    if (!DELAY_LINE_DIRECTION) dir_bad++;
    if (EYE_MONITOR_CLEAR_FLAGS) nclear++;
    if (DELAY_LINE_LOAD) begin
      nload++; tap_m = 0; cyc = 0;
    end else if (DELAY_LINE_MOVE) begin
      nmove++; tap_m++; cyc = 0;
    end else begin
      cyc++;
    end
    drive_inputs();
  endtask

  task automatic begin_run();
    nload = 0; nmove = 0; nclear = 0; tap_m = 0; cyc = NEVER;
    @(negedge FAB_CLK);
    START = 1'b1;
    drive_inputs();
    @(negedge FAB_CLK);
    START = 1'b0;
    step_cycle();
  endtask

  task automatic run_scn(input int mid_start);
    timed_out = 1'b1;
    begin_run();
    for (int n = 0; n < 5000; n++) begin
      @(negedge FAB_CLK);
      step_cycle();
      if (!BUSY && (DONE || ERR)) begin
        timed_out = 1'b0;
        break;
      end
      START = (n == mid_start);
    end
    START = 1'b0;
  endtask

  // Reference: walk the taps applying the evaluation rules directly.
  task automatic model(output bit m_done, output bit m_err, output logic [7:0] m_edge,
                       output int m_moves);
    logic [7:0] cur_w;
    bit unst;
    m_done = 1'b0; m_err = 1'b0; m_edge = 8'd0; m_moves = 0;
    for (int t = 0; t < int'(MAX_TAPS); t++) begin
      cur_w   = (t >= s_edge) ? s_alt : s_ref;
      unst    = (t == s_jit) || (EYE_ON && (t == s_eye));
      m_moves = t;
      if (t >= s_oor) begin m_err = 1'b1; return; end
      if (t == 0) begin
        if (unst) begin m_err = 1'b1; return; end
        ref_model = cur_w;
      end else if (unst || (cur_w != ref_model)) begin
        m_done = 1'b1; m_edge = 8'(t); return;
      end else if (t == int'(MAX_TAPS) - 1) begin
        m_err = 1'b1; return;
      end
    end
  endtask

  task automatic check_run(input string tag, input bit e_done, input bit e_err,
                           input logic [7:0] e_edge, input logic [7:0] e_ref, input int e_moves);
    chk({tag, " timeout"}, int'(timed_out), 0);
    chk({tag, " DONE"}, int'(DONE), int'(e_done));
    chk({tag, " ERR"}, int'(ERR), int'(e_err));
    chk({tag, " EDGE_TAP"}, int'(EDGE_TAP), int'(e_edge));
    chk({tag, " REF_PATTERN"}, int'(REF_PATTERN), int'(e_ref));
    chk({tag, " moves"}, nmove, e_moves);
    chk({tag, " loads"}, nload, 1);
    chk({tag, " clears"}, nclear, EYE_ON ? e_moves + 1 : 0);
  endtask

  task automatic set_scn(input logic [7:0] r, input logic [7:0] a, input int e, input int j,
                         input int o, input int y);
    s_ref = r; s_alt = a; s_edge = e; s_jit = j; s_oor = o; s_eye = y;
  endtask

  initial begin
    bit m_done, m_err;
    logic [7:0] m_edge;
    int m_moves;
    n_pass = 0; n_total = 0; both_hi = 0; dir_bad = 0; ref_model = 8'd0;
    START = 1'b0; RESET_N = 1'b0;
    set_scn(8'hF0, 8'h0F, NEVER, NEVER, NEVER, NEVER);
    tap_m = 0; cyc = NEVER;
    drive_inputs();

    vecs[0] = '{8'hF0, 8'h0F, 37,    NEVER, NEVER, NEVER, 1, 0, 8'd37,  8'hF0, 37};
    vecs[1] = '{8'hF0, 8'h0F, NEVER, NEVER, NEVER, NEVER, 0, 1, 8'd0,   8'hF0, 127};
    vecs[2] = '{8'h5A, 8'hA5, NEVER, 0,     NEVER, NEVER, 0, 1, 8'd0,   8'hF0, 0};
    vecs[3] = '{8'h3C, 8'hC3, NEVER, NEVER, 10,    NEVER, 0, 1, 8'd0,   8'h3C, 10};
    vecs[4] = '{8'hA5, 8'hA4, 1,     NEVER, NEVER, NEVER, 1, 0, 8'd1,   8'hA5, 1};
    vecs[5] = '{8'h81, 8'h18, 127,   NEVER, NEVER, NEVER, 1, 0, 8'd127, 8'h81, 127};
    vecs[6] = '{8'h77, 8'h78, NEVER, NEVER, 0,     NEVER, 0, 1, 8'd0,   8'h81, 0};
    vecs[7] = '{8'hC3, 8'h3C, NEVER, 50,    NEVER, NEVER, 1, 0, 8'd50,  8'hC3, 50};
    vecs[8] = '{8'h11, 8'h22, 20,    NEVER, 20,    NEVER, 0, 1, 8'd0,   8'h11, 20};
`ifdef BCLK_TRN_EYE_MON_EN
    vecs[9] = '{8'hF0, 8'h0F, NEVER, NEVER, NEVER, 20,    1, 0, 8'd20,  8'hF0, 20};
`else
    vecs[9] = '{8'hF0, 8'h0F, NEVER, NEVER, NEVER, 20,    0, 1, 8'd0,   8'hF0, 127};
`endif

    repeat (3) @(negedge FAB_CLK);
    RESET_N = 1'b1;
    @(negedge FAB_CLK);
    chk("reset LOAD", int'(DELAY_LINE_LOAD), 0);
    chk("reset MOVE", int'(DELAY_LINE_MOVE), 0);
    chk("reset DIRECTION", int'(DELAY_LINE_DIRECTION), 1);
    chk("reset CLEAR", int'(EYE_MONITOR_CLEAR_FLAGS), 0);
    chk("reset BUSY", int'(BUSY), 0);
    chk("reset DONE", int'(DONE), 0);
    chk("reset ERR", int'(ERR), 0);
    chk("reset EDGE_TAP", int'(EDGE_TAP), 0);
    chk("reset REF_PATTERN", int'(REF_PATTERN), 0);

    for (int i = 0; i < 10; i++) begin
      set_scn(vecs[i].ref_w, vecs[i].alt_w, vecs[i].edge_t, vecs[i].jit_t,
              vecs[i].oor_t, vecs[i].eye_t);
      run_scn(60);
      check_run($sformatf("vec%0d", i), vecs[i].e_done, vecs[i].e_err,
                vecs[i].e_edge, vecs[i].e_ref, vecs[i].e_moves);
      ref_model = vecs[i].e_ref;
    end

    // Reset during SAMPLE at tap 5 aborts, then a fresh START retrains.
    set_scn(8'h42, 8'h24, NEVER, NEVER, NEVER, NEVER);
    begin_run();
    for (int n = 0; n < 1000; n++) begin
      @(negedge FAB_CLK);
      step_cycle();
      if ((tap_m == 5) && (cyc == int'(SETTLE) + 3)) break;
    end
    chk("abort reached tap5", tap_m, 5);
    RESET_N = 1'b0;
    @(negedge FAB_CLK);
    RESET_N = 1'b1;
    chk("abort LOAD", int'(DELAY_LINE_LOAD), 0);
    chk("abort MOVE", int'(DELAY_LINE_MOVE), 0);
    chk("abort DIRECTION", int'(DELAY_LINE_DIRECTION), 1);
    chk("abort BUSY", int'(BUSY), 0);
    chk("abort DONE", int'(DONE), 0);
    chk("abort ERR", int'(ERR), 0);
    chk("abort EDGE_TAP", int'(EDGE_TAP), 0);
    chk("abort REF_PATTERN", int'(REF_PATTERN), 0);
    nload = 0; nmove = 0;
    repeat (40) begin
      @(negedge FAB_CLK);
      step_cycle();
    end
    chk("abort no pulses", nload + nmove, 0);
    chk("abort stays idle", int'(BUSY), 0);
    ref_model = 8'd0;
    set_scn(8'h42, 8'h24, 6, NEVER, NEVER, NEVER);
    run_scn(NEVER);
    check_run("retrain", 1'b1, 1'b0, 8'd6, 8'h42, 6);
    ref_model = 8'h42;

    for (int r = 0; r < 8; r++) begin
      set_scn(8'($urandom), 8'h00, int'($urandom_range(1, 140)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 140)) : NEVER,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 140)) : NEVER,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 140)) : NEVER);
      s_alt = s_ref ^ 8'($urandom_range(1, 255));
      model(m_done, m_err, m_edge, m_moves);
      run_scn(int'($urandom_range(30, 200)));
      check_run($sformatf("rand%0d", r), m_done, m_err, m_edge, ref_model, m_moves);
    end

    chk("LOAD and MOVE overlap", both_hi, 0);
    chk("DIRECTION low seen", dir_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
